cpu_run_monitor: RTL and testbench

CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

---
 rtl/cpu_run_monitor_pkg.sv | 13 +
 rtl/cpu_run_monitor_snap_fifo.sv | 61 ++++++
 rtl/cpu_run_monitor.sv | 108 ++++++++++
 tb/tb_cpu_run_monitor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_monitor_pkg.sv
// Shared definitions for the CPU run monitor: run-state encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_run_monitor_pkg;

    // RUN is the only live state; HALTED and TIMEOUT hold until reset.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } run_state_t;

endpackage

// File: rtl/cpu_run_monitor_snap_fifo.sv
// Generic synchronous FIFO holding monitor snapshots.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: pop only on pop_valid & pop_ready; a push while full is accepted
//               only if a pop happens on the same edge, otherwise it is dropped.
// Ports: clk/reset_n; push + push_data in; pop_valid/pop_ready/pop_data head
//        interface; full/empty status.
module snap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop;
    logic             push_ok;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop_valid = ~empty;
    assign pop       = pop_valid & pop_ready;
    // A pop on the same edge frees the slot the push needs.
    assign push_ok   = push & (~full | pop);
    assign pop_data  = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Watches a CPU run: counts RUN cycles, detects halt/timeout, queues register snapshots on dump requests.
// Latency: status flags and snapshots appear one cycle after the triggering edge.
// Backpressure: snapshots wait in the FIFO until snap_ready; pushes into a full FIFO are dropped and set sticky overflow.
// Ports: clk/reset_n; halt, dump_state levels; watch_data registers in;
//        snap_valid/snap_ready/snap_data/snap_cycle out; done, timed_out, overflow, cycle_count status.
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 3,
    parameter int TIMEOUT    = 400,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     halt,
    input  logic                     dump_state,
    input  logic [NUM_CH*DATA_W-1:0] watch_data,
    output logic                     snap_valid,
    input  logic                     snap_ready,
    output logic [NUM_CH*DATA_W-1:0] snap_data,
    output logic [CNT_W-1:0]         snap_cycle,
    output logic                     done,
    output logic                     timed_out,
    output logic                     overflow,
    output logic [CNT_W-1:0]         cycle_count
);

    localparam int SNAP_W = CNT_W + NUM_CH*DATA_W;

    run_state_t  state;
    run_state_t  state_nxt;
    logic        halt_q;
    logic        dump_q;
    logic        halt_edge;
    logic        dump_edge;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [SNAP_W-1:0] head;

    // Previous values reset to 0, so a level already high at reset release
    // counts as an edge on the first clock.
    assign halt_edge = halt & ~halt_q;
    assign dump_edge = dump_state & ~dump_q;

    // Dump is sampled against the RUN state of this edge, so a dump that
    // coincides with the halt edge is still captured.
    assign push = dump_edge & (state == ST_RUN);
    assign pop  = snap_valid & snap_ready;

    assign done      = (state == ST_HALTED);
    assign timed_out = (state == ST_TIMEOUT);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                // Halt wins over a coincident timeout.
                if (halt_edge)
                    state_nxt = ST_HALTED;
                else if (cycle_count == CNT_W'(TIMEOUT - 1))
                    state_nxt = ST_TIMEOUT;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_RUN;
            cycle_count <= '0;
            halt_q      <= 1'b0;
            dump_q      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state  <= state_nxt;
            halt_q <= halt;
            dump_q <= dump_state;
            // Counts the transition edge out of RUN as well, then freezes.
            if (state == ST_RUN)
                cycle_count <= cycle_count + 1'b1;
            if (push & fifo_full & ~pop)
                overflow <= 1'b1;
        end
    end

    snap_fifo #(
        .WIDTH (SNAP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_snap_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({cycle_count, watch_data}),
        .pop_valid (snap_valid),
        .pop_ready (snap_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign snap_cycle = head[SNAP_W-1 -: CNT_W];
    assign snap_data  = head[NUM_CH*DATA_W-1:0];

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: timeout, halt, FIFO overflow/bypass, async reset.
// Latency: inputs driven 1 ns after each rising edge, outputs sampled there too.
// Backpressure: snap_ready driven per test.
module tb_cpu_run_monitor;

    localparam int DATA_W     = 32;
    localparam int NUM_CH     = 3;
    localparam int TIMEOUT    = 400;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     halt;
    logic                     dump_state;
    logic [NUM_CH*DATA_W-1:0] watch_data;
    logic                     snap_valid;
    logic                     snap_ready;
    logic [NUM_CH*DATA_W-1:0] snap_data;
    logic [CNT_W-1:0]         snap_cycle;
    logic                     done;
    logic                     timed_out;
    logic                     overflow;
    logic [CNT_W-1:0]         cycle_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_run_monitor #(
        .DATA_W     (DATA_W),
        .NUM_CH     (NUM_CH),
        .TIMEOUT    (TIMEOUT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .halt        (halt),
        .dump_state  (dump_state),
        .watch_data  (watch_data),
        .snap_valid  (snap_valid),
        .snap_ready  (snap_ready),
        .snap_data   (snap_data),
        .snap_cycle  (snap_cycle),
        .done        (done),
        .timed_out   (timed_out),
        .overflow    (overflow),
        .cycle_count (cycle_count)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        halt       = 1'b0;
        dump_state = 1'b0;
        snap_ready = 1'b0;
        watch_data = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Advance until cycle_count == n; the next edge then sees count n.
    task automatic run_to(input int n);
        int guard = 0;
        while (cycle_count != CNT_W'(n) && guard < 1000) begin
            step();
            guard++;
        end
        check_val("run_to", cycle_count, n);
    endtask

    // One dump edge seen at the edge where cycle_count == n; channel values = n.
    task automatic dump_at(input int n);
        run_to(n);
        dump_state = 1'b1;
        watch_data = {DATA_W'(n), DATA_W'(n), DATA_W'(n)};
        step();
        dump_state = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check_val("rst_count", cycle_count, 0);
        check_val("rst_done", done, 0);
        check_val("rst_tout", timed_out, 0);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_valid", snap_valid, 0);

        // Halt edge with coincident dump at cycle 10
        do_reset();
        run_to(10);
        halt       = 1'b1;
        dump_state = 1'b1;
        watch_data = {32'd3, 32'd2, 32'd1};
        step();
        check_val("halt_done", done, 1);
        check_val("halt_tout", timed_out, 0);
        check_val("halt_valid", snap_valid, 1);
        check_val("halt_scycle", snap_cycle, 10);
        check_val("halt_sdata", snap_data, {32'd3, 32'd2, 32'd1});
        check_val("halt_count", cycle_count, 11);
        dump_state = 1'b0;
        step();
        dump_state = 1'b1;  // edge in HALTED: ignored
        step();
        check_val("halt_frozen", cycle_count, 11);
        snap_ready = 1'b1;
        step();
        snap_ready = 1'b0;
        check_val("halt_one_entry", snap_valid, 0);
        check_val("halt_still_done", done, 1);

        // Five dumps into a 4-deep FIFO with no consumer
        do_reset();
        dump_at(2);
        dump_at(4);
        dump_at(6);
        dump_at(8);
        check_val("ovf_before", overflow, 0);
        dump_at(10);
        check_val("ovf_after", overflow, 1);
        check_val("ovf_head_stable", snap_cycle, 2);
        snap_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("ovf_pop_valid", snap_valid, 1);
            check_val("ovf_pop_cycle", snap_cycle, 2 + 2*i);
            check_val("ovf_pop_data", snap_data[DATA_W-1:0], 2 + 2*i);
            step();
        end
        snap_ready = 1'b0;
        check_val("ovf_drained", snap_valid, 0);
        check_val("ovf_sticky", overflow, 1);

        // Full FIFO, push with simultaneous pop
        do_reset();
        dump_at(2);
        dump_at(4);
        dump_at(6);
        dump_at(8);
        run_to(10);
        dump_state = 1'b1;
        snap_ready = 1'b1;
        watch_data = {32'd10, 32'd10, 32'd10};
        step();
        dump_state = 1'b0;
        snap_ready = 1'b0;
        check_val("byp_ovf", overflow, 0);
        check_val("byp_head", snap_cycle, 4);
        snap_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("byp_pop_valid", snap_valid, 1);
            check_val("byp_pop_cycle", snap_cycle, 4 + 2*i);
            step();
        end
        snap_ready = 1'b0;
        check_val("byp_drained", snap_valid, 0);

        // Asynchronous reset mid-run with two entries queued
        do_reset();
        dump_at(2);
        dump_at(4);
        run_to(6);
        halt = 1'b1;
        step();
        check_val("arst_pre_valid", snap_valid, 1);
        check_val("arst_pre_done", done, 1);
        #2;
        reset_n    = 1'b0;
        dump_state = 1'b1;  // held across release
        halt       = 1'b0;
        #1;
        check_val("arst_valid", snap_valid, 0);
        check_val("arst_count", cycle_count, 0);
        check_val("arst_done", done, 0);
        check_val("arst_tout", timed_out, 0);
        check_val("arst_ovf", overflow, 0);

        // Dump held high across reset release: single capture at cycle 0
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_val("rel_valid", snap_valid, 1);
        check_val("rel_scycle", snap_cycle, 0);
        check_val("rel_count", cycle_count, 1);
        repeat (3) step();
        snap_ready = 1'b1;
        step();
        snap_ready = 1'b0;
        dump_state = 1'b0;
        check_val("rel_one_entry", snap_valid, 0);

        // Idle run to timeout
        do_reset();
        run_to(TIMEOUT - 1);
        check_val("tout_pre", timed_out, 0);
        step();
        check_val("tout_flag", timed_out, 1);
        check_val("tout_count", cycle_count, TIMEOUT);
        check_val("tout_done", done, 0);
        repeat (5) step();
        check_val("tout_frozen", cycle_count, TIMEOUT);
        halt       = 1'b1;
        dump_state = 1'b1;
        step();
        check_val("tout_no_halt", done, 0);
        check_val("tout_no_dump", snap_valid, 0);

        // Halt edge coinciding with timeout: halt wins
        do_reset();
        run_to(TIMEOUT - 1);
        halt = 1'b1;
        step();
        check_val("prio_done", done, 1);
        check_val("prio_tout", timed_out, 0);
        check_val("prio_count", cycle_count, TIMEOUT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
